// File: rtl/pattern_scan_arb.sv
// ---------------------------------------------------------------------------
// pattern_scan_arb
//
// Purpose:
//   Round-robin arbiter in front of one shared serial "01" pattern detector.
//   Four requesters each present a DATA_W-bit word. The winner's word is
//   captured and shifted through the detector one bit per cycle. The number
//   of "0 followed by 1" occurrences is counted, and the total is reported
//   with a one-cycle done pulse.
//
// Configuration macro:
//   PSA_MSB_FIRST_EN  defined   -> words are shifted MSB first
//                     undefined -> words are shifted LSB first (default)
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   req        in   [NREQ]          level-sensitive scan requests
//   req_data   in   [NREQ*DATA_W]   requester i word at [i*DATA_W +: DATA_W]
//   gnt        out  [NREQ]          one-hot grant, one-cycle pulse
//   busy       out                  FSM is not idle
//   ser_a      out                  bit currently fed to the detector
//   match      out                  Mealy detector output (combinational)
//   done       out                  one-cycle job-complete pulse
//   done_id    out  [2]             requester of the last completed job
//   match_cnt  out  [CNT_W]         match count of the last completed job
// ---------------------------------------------------------------------------
module pattern_scan_arb #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     ser_a,
    output logic                     match,
    output logic                     done,
    output logic [1:0]               done_id,
    output logic [CNT_W-1:0]         match_cnt
);

    // Requester index width. NREQ is fixed at 4, so a 2-bit index wraps
    // modulo NREQ on its own.
    localparam int ID_W = 2;
    localparam int BC_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic {
        S0 = 1'b0,
        S1 = 1'b1
    } det_t;

    state_t              r_state;
    det_t                r_det;
    logic [DATA_W-1:0]   r_shift;
    logic [BC_W-1:0]     r_bit_cnt;
    logic [CNT_W-1:0]    r_run_cnt;
    logic [ID_W-1:0]     r_last;
    logic [NREQ-1:0]     r_gnt;
    logic                r_done;
    logic [ID_W-1:0]     r_done_id;
    logic [CNT_W-1:0]    r_match_cnt;

    logic [ID_W-1:0]     w_winner;
    logic [ID_W-1:0]     w_idx;
    logic                w_found;
    logic                w_cur_bit;
    logic                w_shifting;
    logic [DATA_W-1:0]   w_shift_next;
    logic [CNT_W-1:0]    w_run_next;

    // Round-robin search. The search starts one past the last winner and
    // walks all NREQ positions, so the last winner has the lowest priority.
    always_comb begin
        w_winner = r_last;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = r_last + ID_W'(k);
            if (!w_found && req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

`ifdef PSA_MSB_FIRST_EN
    assign w_cur_bit    = r_shift[DATA_W-1];
    assign w_shift_next = {r_shift[DATA_W-2:0], 1'b0};
`else
    assign w_cur_bit    = r_shift[0];
    assign w_shift_next = {1'b0, r_shift[DATA_W-1:1]};
`endif

    assign w_shifting = (r_state == ST_SHIFT);
    assign ser_a      = w_shifting & w_cur_bit;
    assign match      = ser_a & (r_det == S1);

    // The count includes this cycle's match and saturates at all-ones.
    assign w_run_next = (match && (r_run_cnt != {CNT_W{1'b1}}))
                      ? r_run_cnt + CNT_W'(1) : r_run_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_det       <= S0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_run_cnt   <= '0;
            r_last      <= ID_W'(NREQ - 1);
            r_gnt       <= '0;
            r_done      <= 1'b0;
            r_done_id   <= '0;
            r_match_cnt <= '0;
        end else begin
            // Grant and done are single-cycle pulses by default.
            r_gnt  <= '0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_shift   <= req_data[int'(w_winner)*DATA_W +: DATA_W];
                        r_bit_cnt <= '0;
                        r_run_cnt <= '0;
                        r_det     <= S0;
                        r_gnt     <= NREQ'(1) << w_winner;
                        r_last    <= w_winner;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shift   <= w_shift_next;
                    // A 0 arms the detector, a 1 disarms it.
                    r_det     <= w_cur_bit ? S0 : S1;
                    r_bit_cnt <= r_bit_cnt + BC_W'(1);
                    r_run_cnt <= w_run_next;
                    if (r_bit_cnt == BC_W'(DATA_W - 1)) begin
                        // Last bit: publish the result so it is visible
                        // during the DONE cycle.
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_done_id   <= r_last;
                        r_match_cnt <= w_run_next;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign match_cnt = r_match_cnt;

endmodule
